// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite read arbiter: response codes, arbiter state, default widths.
package axi4_lite_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi4_lite_grant_picker.sv
// Two-requester grant picker: a sole requester wins; on a tie the master not granted last wins.
module axi4_lite_grant_picker (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) grant = ~last_grant;
    else if (req[1])  grant = 1'b1;
  end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Two-master AXI4-Lite read arbiter in front of one slave, one outstanding read at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise M0 wins every tie.
module axi4_lite_read_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] M0_AR_ADDR,
  input  logic              M0_AR_VALID,
  output logic              M0_AR_READY,
  output logic [DATA_W-1:0] M0_R_DATA,
  output logic [1:0]        M0_R_RESP,
  output logic              M0_R_VALID,
  input  logic              M0_R_READY,
  input  logic [ADDR_W-1:0] M1_AR_ADDR,
  input  logic              M1_AR_VALID,
  output logic              M1_AR_READY,
  output logic [DATA_W-1:0] M1_R_DATA,
  output logic [1:0]        M1_R_RESP,
  output logic              M1_R_VALID,
  input  logic              M1_R_READY,
  output logic [ADDR_W-1:0] S_AR_ADDR,
  output logic              S_AR_VALID,
  input  logic              S_AR_READY,
  input  logic [DATA_W-1:0] S_R_DATA,
  input  logic [1:0]        S_R_RESP,
  input  logic              S_R_VALID,
  output logic              S_R_READY,
  output logic              GRANT,
  output logic              BUSY
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic [1:0] req;
  logic       pick;
  logic       last_grant;

  assign req = {M1_AR_VALID, M0_AR_VALID};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == ARB_IDLE && |req) last_d = pick;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign last_grant = last_q;
`else
  // Pretending M1 always won last makes the picker resolve ties to M0.
  assign last_grant = 1'b1;
`endif

  axi4_lite_grant_picker u_picker (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // Granted master's view of its own inputs.
  logic              sel_ar_valid;
  logic [ADDR_W-1:0] sel_ar_addr;
  logic              sel_r_ready;

  assign sel_ar_valid = grant_q ? M1_AR_VALID : M0_AR_VALID;
  assign sel_ar_addr  = grant_q ? M1_AR_ADDR  : M0_AR_ADDR;
  assign sel_r_ready  = grant_q ? M1_R_READY  : M0_R_READY;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ARB_IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d = ARB_ADDR;
          grant_d = pick;
        end
      end
      ARB_ADDR: if (sel_ar_valid && S_AR_READY) state_d = ARB_DATA;
      ARB_DATA: if (S_R_VALID && sel_r_ready)   state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    M0_AR_READY = 1'b0;
    M1_AR_READY = 1'b0;
    M0_R_VALID  = 1'b0;
    M1_R_VALID  = 1'b0;
    M0_R_DATA   = '0;
    M1_R_DATA   = '0;
    M0_R_RESP   = 2'b00;
    M1_R_RESP   = 2'b00;
    S_AR_ADDR   = '0;
    S_AR_VALID  = 1'b0;
    S_R_READY   = 1'b0;
    GRANT       = grant_q;
    BUSY        = (state_q != ARB_IDLE);
    case (state_q)
      ARB_ADDR: begin
        S_AR_VALID = sel_ar_valid;
        S_AR_ADDR  = sel_ar_addr;
        if (grant_q) M1_AR_READY = S_AR_READY;
        else         M0_AR_READY = S_AR_READY;
      end
      ARB_DATA: begin
        S_R_READY = sel_r_ready;
        if (grant_q) begin
          M1_R_VALID = S_R_VALID;
          M1_R_DATA  = S_R_DATA;
          M1_R_RESP  = S_R_RESP;
        end else begin
          M0_R_VALID = S_R_VALID;
          M0_R_DATA  = S_R_DATA;
          M0_R_RESP  = S_R_RESP;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Bench for axi4_lite_read_arbiter: transaction-level model compared every cycle, plus directed scenarios.
module tb_axi4_lite_read_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [AW-1:0] m0_ar_addr, m1_ar_addr, s_ar_addr;
  logic          m0_ar_valid, m1_ar_valid, m0_ar_ready, m1_ar_ready;
  logic [DW-1:0] m0_r_data, m1_r_data, s_r_data;
  logic [1:0]    m0_r_resp, m1_r_resp, s_r_resp;
  logic          m0_r_valid, m1_r_valid, m0_r_ready, m1_r_ready;
  logic          s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic          grant, busy;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  axi4_lite_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M0_AR_ADDR(m0_ar_addr), .M0_AR_VALID(m0_ar_valid), .M0_AR_READY(m0_ar_ready),
    .M0_R_DATA(m0_r_data), .M0_R_RESP(m0_r_resp), .M0_R_VALID(m0_r_valid), .M0_R_READY(m0_r_ready),
    .M1_AR_ADDR(m1_ar_addr), .M1_AR_VALID(m1_ar_valid), .M1_AR_READY(m1_ar_ready),
    .M1_R_DATA(m1_r_data), .M1_R_RESP(m1_r_resp), .M1_R_VALID(m1_r_valid), .M1_R_READY(m1_r_ready),
    .S_AR_ADDR(s_ar_addr), .S_AR_VALID(s_ar_valid), .S_AR_READY(s_ar_ready),
    .S_R_DATA(s_r_data), .S_R_RESP(s_r_resp), .S_R_VALID(s_r_valid), .S_R_READY(s_r_ready),
    .GRANT(grant), .BUSY(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one read in flight, tracked as "none / waiting for AR accept / waiting for R beat".
  int   m_stage = 0;   // 0 none, 1 address pending, 2 data pending
  logic m_owner = 1'b0;
  logic m_last  = 1'b1;
  bit   m_ok    = 1'b0;

  function automatic logic pick_owner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return RR ? ~last : 1'b0;
    return v1;
  endfunction

  always @(negedge CLK) begin
    logic o, own0, own1, arv_o, rr_o;
    o     = m_owner;
    own0  = (o == 1'b0);
    own1  = (o == 1'b1);
    arv_o = o ? m1_ar_valid : m0_ar_valid;
    rr_o  = o ? m1_r_ready : m0_r_ready;
    if (m_ok) begin
      chk("busy",       64'(busy),        64'(m_stage != 0));
      chk("grant",      64'(grant),       64'(o));
      chk("s_ar_valid", 64'(s_ar_valid),  64'(m_stage == 1 && arv_o));
      if (m_stage == 1) chk("s_ar_addr", s_ar_addr, o ? m1_ar_addr : m0_ar_addr);
      chk("m0_ar_ready", 64'(m0_ar_ready), 64'(m_stage == 1 && own0 && s_ar_ready));
      chk("m1_ar_ready", 64'(m1_ar_ready), 64'(m_stage == 1 && own1 && s_ar_ready));
      chk("s_r_ready",   64'(s_r_ready),   64'(m_stage == 2 && rr_o));
      chk("m0_r_valid",  64'(m0_r_valid),  64'(m_stage == 2 && own0 && s_r_valid));
      chk("m1_r_valid",  64'(m1_r_valid),  64'(m_stage == 2 && own1 && s_r_valid));
      chk("m0_r_data",   m0_r_data, (m_stage == 2 && own0) ? s_r_data : 64'd0);
      chk("m1_r_data",   m1_r_data, (m_stage == 2 && own1) ? s_r_data : 64'd0);
      chk("m0_r_resp",   64'(m0_r_resp), (m_stage == 2 && own0) ? 64'(s_r_resp) : 64'd0);
      chk("m1_r_resp",   64'(m1_r_resp), (m_stage == 2 && own1) ? 64'(s_r_resp) : 64'd0);
    end
    // Inputs are stable until the next rising edge, so advance the model now.
    if (!RST_N) begin
      m_stage = 0; m_owner = 1'b0; m_last = 1'b1; m_ok = 1'b1;
    end else if (m_stage == 0) begin
      if (m0_ar_valid || m1_ar_valid) begin
        m_owner = pick_owner(m0_ar_valid, m1_ar_valid, m_last);
        m_last  = m_owner;
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      if (arv_o && s_ar_ready) m_stage = 2;
    end else begin
      if (s_r_valid && rr_o) m_stage = 0;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic quiet();
    m0_ar_addr = '0; m1_ar_addr = '0; m0_ar_valid = 0; m1_ar_valid = 0;
    m0_r_ready = 0; m1_r_ready = 0; s_ar_ready = 0;
    s_r_data = '0; s_r_resp = 2'b00; s_r_valid = 0;
  endtask

  task automatic reset_dut();
    quiet();
    RST_N = 0;
    repeat (2) tick();
    RST_N = 1;
  endtask

  logic gseq [4];
  logic exp_g;

  initial begin
    quiet();
    reset_dut();
    @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_s_ar_valid", 64'(s_ar_valid), 64'd0);

    // Lone M0 read, slave answers DEAD_BEEF three cycles after AR accept.
    tick();
    m0_ar_addr = 64'h8000_0000; m0_ar_valid = 1; s_ar_ready = 1; m0_r_ready = 1;
    tick();
    @(negedge CLK);
    chk("t1_s_ar_valid", 64'(s_ar_valid), 64'd1);
    chk("t1_s_ar_addr", s_ar_addr, 64'h8000_0000);
    tick();
    m0_ar_valid = 0; s_ar_ready = 0;
    @(negedge CLK);
    chk("t1_wait_rvalid", 64'(m0_r_valid), 64'd0);
    tick(); tick();
    s_r_valid = 1; s_r_data = 64'hDEAD_BEEF; s_r_resp = 2'b00;
    @(negedge CLK);
    chk("t1_m0_r_data", m0_r_data, 64'hDEAD_BEEF);
    chk("t1_m0_r_valid", 64'(m0_r_valid), 64'd1);
    chk("t1_m1_r_valid", 64'(m1_r_valid), 64'd0);
    tick();
    s_r_valid = 0;
    @(negedge CLK);
    chk("t1_busy_done", 64'(busy), 64'd0);

    // Four ties in a row with both masters always requesting.
    reset_dut();
    m0_ar_valid = 1; m1_ar_valid = 1; m0_ar_addr = 64'h10; m1_ar_addr = 64'h20;
    s_ar_ready = 1; s_r_valid = 1; m0_r_ready = 1; m1_r_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge CLK);
      gseq[k] = grant;
      tick(); tick();
    end
    for (int k = 0; k < 4; k++) begin
      exp_g = RR ? ((k % 2) == 1) : 1'b0;
      chk($sformatf("t2_grant%0d", k), 64'(gseq[k]), 64'(exp_g));
    end

    // M1 read with AR stalled five cycles, then R stalled four cycles with SLVERR.
    reset_dut();
    m1_ar_addr = 64'h0000_1234_5678_9ABC; m1_ar_valid = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("t3_s_ar_valid", 64'(s_ar_valid), 64'd1);
      chk("t3_addr", s_ar_addr, 64'h0000_1234_5678_9ABC);
      chk("t3_grant", 64'(grant), 64'd1);
      chk("t3_busy", 64'(busy), 64'd1);
      tick();
    end
    s_ar_ready = 1;
    @(negedge CLK);
    chk("t3_m1_ar_ready", 64'(m1_ar_ready), 64'd1);
    tick();
    m1_ar_valid = 0; s_ar_ready = 0; s_r_valid = 1; s_r_resp = 2'b10; s_r_data = 64'h55;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("t4_s_r_ready", 64'(s_r_ready), 64'd0);
      chk("t4_m1_r_valid", 64'(m1_r_valid), 64'd1);
      tick();
    end
    m1_r_ready = 1;
    @(negedge CLK);
    chk("t4_m1_r_resp", 64'(m1_r_resp), 64'd2);
    chk("t4_s_r_ready_go", 64'(s_r_ready), 64'd1);
    tick();
    s_r_valid = 0;
    @(negedge CLK);
    chk("t4_busy_done", 64'(busy), 64'd0);

    // Reset landing in the middle of an M1 data phase.
    reset_dut();
    m1_ar_valid = 1; m1_ar_addr = 64'h40; s_ar_ready = 1;
    tick(); tick();
    m1_ar_valid = 0; s_ar_ready = 0; s_r_valid = 1; RST_N = 0;
    @(negedge CLK);
    chk("t5_pre_busy", 64'(busy), 64'd1);
    tick();
    @(negedge CLK);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_grant", 64'(grant), 64'd0);
    chk("t5_m1_r_valid", 64'(m1_r_valid), 64'd0);
    chk("t5_s_r_ready", 64'(s_r_ready), 64'd0);
    RST_N = 1; s_r_valid = 0;
    tick();
    @(negedge CLK);
    chk("t5_no_replay", 64'(busy), 64'd0);

    // M1 arrives while M0 is in its data phase; served only after an IDLE cycle.
    reset_dut();
    m0_ar_valid = 1; m0_ar_addr = 64'hA0; s_ar_ready = 1; m0_r_ready = 1; m1_r_ready = 1;
    tick(); tick();
    m0_ar_valid = 0; m1_ar_valid = 1; m1_ar_addr = 64'hB0; s_r_valid = 1;
    @(negedge CLK);
    chk("t6_m1_ar_ready", 64'(m1_ar_ready), 64'd0);
    tick();
    s_r_valid = 0;
    @(negedge CLK);
    chk("t6_idle_gap", 64'(busy), 64'd0);
    tick();
    @(negedge CLK);
    chk("t6_grant", 64'(grant), 64'd1);
    chk("t6_addr", s_ar_addr, 64'hB0);
    tick();
    m1_ar_valid = 0; s_r_valid = 1;
    tick();
    s_r_valid = 0;

    // Random traffic, including protocol violations and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      RST_N       = ($urandom_range(0, 199) != 0);
      m0_ar_valid = $urandom_range(0, 1);
      m1_ar_valid = $urandom_range(0, 1);
      m0_ar_addr  = {$urandom, $urandom};
      m1_ar_addr  = {$urandom, $urandom};
      m0_r_ready  = ($urandom_range(0, 3) != 0);
      m1_r_ready  = ($urandom_range(0, 3) != 0);
      s_ar_ready  = ($urandom_range(0, 2) != 0);
      s_r_valid   = $urandom_range(0, 1);
      s_r_data    = {$urandom, $urandom};
      s_r_resp    = 2'($urandom_range(0, 3));
      tick();
    end

    quiet();
    RST_N = 1;
    tick();
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
